// File: rtl/tx_fifo.sv
// Transmit byte buffer between the host-side writer and the TX packet encoder.
// Show-ahead FIFO with occupancy, full/empty status and one-cycle error pulses.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     store_tx_data,
    input  logic [WIDTH-1:0]         tx_data_in,
    input  logic                     get_tx_packet_data,
    output logic [WIDTH-1:0]         tx_packet_data,
    output logic [$clog2(DEPTH):0]   buffer_occupancy,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_COUNT = OW'(DEPTH);
    localparam logic [AW-1:0] PTR_STEP   = AW'(1);
    localparam logic [OW-1:0] COUNT_STEP = OW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [OW-1:0]    count;

    logic [AW-1:0]    wr_ptr_next, rd_ptr_next;
    logic [OW-1:0]    count_next;
    logic             overflow_next, underflow_next;
    logic             do_push, do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Head is driven from registered state only; an empty buffer always shows zero.
    assign tx_packet_data   = empty ? '0 : mem[rd_ptr];
    assign buffer_occupancy = count;

    // A pop frees a slot in the same cycle, so a push into a full buffer survives
    // when paired with a pop. A pop never benefits from a same-cycle push.
    assign do_pop  = get_tx_packet_data && !empty;
    assign do_push = store_tx_data && (!full || do_pop);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        count_next     = count;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;

        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr + PTR_STEP;
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr + PTR_STEP;
            end

            unique case ({do_push, do_pop})
                2'b10:   count_next = count + COUNT_STEP;
                2'b01:   count_next = count - COUNT_STEP;
                default: count_next = count;
            endcase

            overflow_next  = store_tx_data && !do_push;
            underflow_next = get_tx_packet_data && empty;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!n_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            count         <= count_next;
            overflow_err  <= overflow_next;
            underflow_err <= underflow_next;
        end
    end

    // Storage lives in its own process so the array stays a plain register file.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset because the block is defined to come out of reset
        // with zeroed storage; clear leaves it alone since the empty head masks it.
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!clear && do_push) begin
            mem[wr_ptr] <= tx_data_in;
        end
    end

endmodule

// File: tb/tb_tx_fifo.sv
// Directed bench for tx_fifo: expected bytes are queued as stimulus is issued and
// a separate monitor compares them against the head whenever a valid pop occurs.
module tb_tx_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             n_rst;
    logic             clear;
    logic             store_tx_data;
    logic [WIDTH-1:0] tx_data_in;
    logic             get_tx_packet_data;
    logic [WIDTH-1:0] tx_packet_data;
    logic [OW-1:0]    buffer_occupancy;
    logic             full;
    logic             empty;
    logic             overflow_err;
    logic             underflow_err;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .clear              (clear),
        .store_tx_data      (store_tx_data),
        .tx_data_in         (tx_data_in),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .full               (full),
        .empty              (empty),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (n_rst && !clear && get_tx_packet_data && !empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_data: got 0x%0h, expected no byte available", tx_packet_data);
            end else begin
                check("pop_data", {24'h0, tx_packet_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus; acc says whether this push is expected to be stored.
    task automatic step(input logic psh, input logic [7:0] d, input logic pp, input logic acc);
        store_tx_data      = psh;
        tx_data_in         = d;
        get_tx_packet_data = pp;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
    endtask

    task automatic check_status(input string tag, input int occ, input logic e, input logic f,
                                input logic [7:0] head, input logic ovf, input logic unf);
        check({tag, "_occ"},   32'(buffer_occupancy), 32'(occ));
        check({tag, "_empty"}, 32'(empty),            32'(e));
        check({tag, "_full"},  32'(full),             32'(f));
        check({tag, "_head"},  32'(tx_packet_data),   32'(head));
        check({tag, "_ovf"},   32'(overflow_err),     32'(ovf));
        check({tag, "_unf"},   32'(underflow_err),    32'(unf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst              = 1'b0;
        clear              = 1'b0;
        store_tx_data      = 1'b0;
        tx_data_in         = '0;
        get_tx_packet_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        n_rst = 1'b1;

        // Basic ordering
        step(1'b1, 8'hA1, 1'b0, 1'b1);
        step(1'b1, 8'hB2, 1'b0, 1'b1);
        step(1'b1, 8'hC3, 1'b0, 1'b1);
        check_status("three", 3, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop1_head", 32'(tx_packet_data), 32'hB2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop2_head", 32'(tx_packet_data), 32'hC3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("drained", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, overflow drop, drain
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        check_status("filled", 8, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check_status("overflow", 8, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_pulse_end", 32'(overflow_err), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("drain8", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Underflow, repeated, then push+pop while empty
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("underflow1", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("underflow2_unf", 32'(underflow_err), 32'h1);
        step(1'b1, 8'h66, 1'b1, 1'b1);
        check_status("pushpop_empty", 1, 1'b0, 1'b0, 8'h66, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("unf_pulse_end", 32'(underflow_err), 32'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop66_empty", 32'(empty), 32'h1);

        // Push+pop while full
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        check_status("pushpop_full", 8, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("drain_55", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Wrap-around
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
        check_status("wrap", 5, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_empty", 32'(empty), 32'h1);

        // Clear with a simultaneous push
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
        check("pre_clear_occ", 32'(buffer_occupancy), 32'd4);
        exp_q.delete();
        clear = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        clear = 1'b0;
        check_status("clear", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-fill
        step(1'b1, 8'h81, 1'b0, 1'b1);
        step(1'b1, 8'h82, 1'b0, 1'b1);
        exp_q.delete();
        n_rst = 1'b0;
        step(1'b1, 8'h83, 1'b1, 1'b0);
        check_status("midreset", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        n_rst = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b1);
        check_status("after_reset", 1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        check("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
- Transmit-side data buffer for the USB endpoint datapath.
- Accepts bytes written by the host-side interface and hands them, in order, to the TX packet encoder.
- The encoder pops one byte per get_tx_packet_data strobe.
- Provides occupancy and error status to the protocol controller, and can be flushed on packet abort.

Parameters:
- DEPTH, 8, number of byte entries; power of two, at least 2.
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- clear  input  1  synchronous flush of all contents and status.
- store_tx_data  input  1  write strobe; pushes tx_data_in when asserted.
- tx_data_in  input  WIDTH  byte to push.
- get_tx_packet_data  input  1  read strobe from the TX encoder; pops the head entry.
- tx_packet_data  output  WIDTH  head entry (show-ahead).
- buffer_occupancy  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- full  output  1  high when buffer_occupancy == DEPTH.
- empty  output  1  high when buffer_occupancy == 0.
- overflow_err  output  1  one-cycle pulse flagging a dropped write.
- underflow_err  output  1  one-cycle pulse flagging a pop from an empty buffer.

Behaviour:
- Storage is a register array of DEPTH x WIDTH with a write pointer, a read pointer and an occupancy counter.
  - Both pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH (DEPTH-1 -> 0).
- Reset (n_rst == 0 at a rising edge):
  - Pointers, occupancy and all storage entries go to 0.
  - overflow_err and underflow_err go to 0.
  - Resulting outputs: tx_packet_data = 0, empty = 1, full = 0.
  - A reset mid-operation discards all contents with no error pulse.
- Priority per cycle: n_rst, then clear, then normal push/pop.
- clear == 1:
  - Pointers and occupancy go to 0 and both error flags go to 0.
  - Any push or pop strobe in the same cycle is ignored.
  - Storage contents need not be zeroed, but tx_packet_data must read 0 while empty.
- Push (store_tx_data == 1, not full, or full with a valid pop in the same cycle):
  - mem[wr_ptr] <= tx_data_in, then wr_ptr increments.
- Pop (get_tx_packet_data == 1 and not empty):
  - rd_ptr increments.
  - The entry leaving is the one visible on tx_packet_data during the strobe cycle.
- Show-ahead output:
  - tx_packet_data = mem[rd_ptr] when empty == 0, else 0.
  - Combinational from registered state only, with no path from the strobes.
  - A byte pushed at edge N is visible on tx_packet_data after edge N if the buffer was empty.
- Occupancy: +1 on push only, -1 on pop only, unchanged on push+pop or neither. full and empty derive from the registered occupancy.
- Simultaneous push and pop:
  - When full: both succeed and occupancy stays DEPTH; no overflow.
  - When empty: the push succeeds, the pop is rejected and underflow_err pulses; occupancy becomes 1.
  - Otherwise: both succeed and occupancy is unchanged.
- Overflow:
  - store_tx_data while full without a pop drops the data and leaves all state unchanged.
  - overflow_err is high for exactly the next cycle.
- Underflow:
  - get_tx_packet_data while empty leaves pointers unchanged.
  - underflow_err is high for exactly the next cycle.
- Error flags are registered pulses, not sticky. Repeated offending strobes keep them high for consecutive cycles.
- Latency: one cycle from strobe to updated occupancy, flags and head.

Test Plan:
- Reset, then push 0xA1, 0xB2, 0xC3 on consecutive cycles -> occupancy 3, empty 0, tx_packet_data 0xA1. Pop three times -> 0xB2, then 0xC3, then empty = 1 with tx_packet_data 0x00.
- Push 8 bytes 0x10..0x17, then a 9th push of 0xFF -> full 1, occupancy 8, overflow_err high for one cycle. Pop all 8 -> sequence 0x10..0x17, and 0xFF never appears.
- Pop on an empty buffer -> underflow_err pulse, occupancy 0. Then push+pop together while empty -> occupancy 1, underflow_err pulse, head equals the pushed byte.
- Fill to 8, then push 0x55 with a pop together -> occupancy stays 8, no overflow, head advances. After draining, 0x55 is the last byte out.
- Wrap-around: push 6 and pop 6, then push 5 bytes 0x20..0x24 -> pointers wrap, and bytes pop in order 0x20..0x24.
- With 4 entries, assert clear together with store_tx_data -> occupancy 0, empty 1, tx_packet_data 0, errors 0. Separately, drive n_rst = 0 mid-fill -> all outputs at reset values after the edge.
